usbkeys_tx: RTL and testbench
=============================

// Module: usbkeys_tx
// PURPOSE
//   Inverse of the USB-keyboard byte parser: takes one ASCII key at a time and emits the
//   6-byte keyboard packet (57 AB 01, mask, 00, scan code), then by default a 6-byte release packet.
//   Sits between a key source (terminal test driver, UART RX, scripted ROM) and the byte
//   stream consumed by the parser; used for loopback, replay and bench stimulus.
// PARAMETERS
//   MAGIC        24'h57AB01  3-byte sync prefix, sent MSB byte first
//   SEND_RELEASE 1           1: send release packet (mask 00, code 00) after each press packet
//   GAP          0           idle cycles forced after each packet (0..255), o_byte_valid low
// PORTS
//   i_clk          in   1  clock
//   i_rst          in   1  synchronous reset, active high
//   i_key          in   8  ASCII key to send
//   i_key_valid    in   1  i_key valid
//   o_key_ready    out  1  block accepts a key this cycle
//   o_byte         out  8  stream byte
//   o_byte_valid   out  1  o_byte valid
//   i_byte_ready   in   1  downstream accepts o_byte this cycle
//   o_unmapped     out  1  1-cycle pulse: accepted key had no scan code, dropped
// BEHAVIOUR
//   - Single clock i_clk; reset synchronous, active high. Reset values: o_key_ready=1, o_byte_valid=0,
//     o_byte=00, o_unmapped=0, state IDLE, byte index 0, gap counter 0.
//   - Handshakes: transfer iff valid&&ready at the rising edge. o_byte/o_byte_valid stay stable
//     while o_byte_valid=1 and i_byte_ready=0; o_byte_valid never drops without a transfer.
//   - Key map (combinational, on i_key; mask,code in hex):
//     'a'-'z' -> 00, 04..1D | 'A'-'Z' -> 02, 04..1D | '1'-'9' -> 00, 1E..26 | '0' -> 00, 27
//     0x0D -> 00, 28 | 0x1B -> 00, 29 | 0x08 -> 00, 2A | 0x09 -> 00, 2B | 0x20 -> 00, 2C
//     any other value: unmapped.
//   - FSM: IDLE, PRESS, GAP_P, RELEASE, GAP_R.
//     IDLE: o_key_ready=1. On key transfer: mapped -> latch mask/code, idx=0, go PRESS
//       (o_key_ready=0, o_byte_valid=1, o_byte=57 on next cycle); unmapped -> o_unmapped=1
//       next cycle only, stay IDLE, no bytes emitted.
//     PRESS: o_byte = {MAGIC[23:16],MAGIC[15:8],MAGIC[7:0],mask,00,code}[idx]; idx++ per
//       transfer; transfer of idx 5 -> GAP_P with counter=GAP.
//     GAP_P: o_byte_valid=0; counter decrements per cycle; at 0 (GAP=0: immediately, zero extra
//       cycles) -> RELEASE (idx=0) if SEND_RELEASE else IDLE.
//     RELEASE: same as PRESS with mask=00, code=00; after idx 5 -> GAP_R.
//     GAP_R: as GAP_P, then -> IDLE.
//   - o_key_ready=0 in every state except IDLE; a key offered then is held off, not lost.
//   - Latency (GAP=0, ready=1): key accept at cycle N -> bytes on N+1..N+6 (press),
//     N+7..N+12 (release), o_key_ready=1 at N+13, next accept earliest N+13.
//   - Valid and ready are registered; no combinational path from i_byte_ready to o_key_ready.
//   - idx is 3 bits, 0..5 only; never wraps past 5. Gap counter 8 bits; GAP>255 illegal.
//   - i_rst mid-packet: abort at once, partial packet left truncated (parser resyncs on MAGIC);
//     latched key discarded; reset values above apply the cycle after.
//   - i_rst together with i_key_valid: key ignored (not accepted, no o_unmapped).
// TESTING
//   1. 'a' (0x61), ready=1, GAP=0 -> 57 AB 01 00 00 04, 57 AB 01 00 00 00 on 12 consecutive cycles.
//   2. 'A' (0x41) -> press packet 57 AB 01 02 00 04; '0' -> code 27; 0x0D -> code 28.
//   3. Random i_byte_ready (50%) over 200 keys -> o_byte stable while stalled, byte order exact,
//      o_key_ready only high in IDLE.
//   4. '~' (0x7E) -> o_unmapped 1 for exactly one cycle, o_byte_valid stays 0, o_key_ready stays 1.
//   5. GAP=4, SEND_RELEASE=0, keys "ab" back to back -> 4 idle cycles after each packet,
//      no release packets, second key accepted only after first gap ends.
//   6. i_rst after 3 bytes of 'z' -> o_byte_valid 0 next cycle; then "Hi 1\r" through the
//      keyboard-stream parser in loopback -> parser outputs H,i,space,1,CR in order.

Source files
------------

// File: rtl/usbkeys_tx.sv
// ASCII key to USB-keyboard byte stream: one press packet (MAGIC, mask, 00, code) per key,
// optionally followed by a release packet, with an optional idle gap after each packet.
module usbkeys_tx #(
   parameter logic [23:0] MAGIC        = 24'h57AB01,
   parameter bit          SEND_RELEASE = 1'b1,
   parameter int unsigned GAP          = 0
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [7:0] i_key,
   input  logic       i_key_valid,
   output logic       o_key_ready,
   output logic [7:0] o_byte,
   output logic       o_byte_valid,
   input  logic       i_byte_ready,
   output logic       o_unmapped
);

   localparam logic [7:0] GAP_CYC = 8'(GAP);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRESS,
      ST_GAP_P,
      ST_RELEASE,
      ST_GAP_R
   } state_t;

   state_t     r_state;
   logic [2:0] r_idx;
   logic [7:0] r_gap_cnt;
   logic [7:0] r_mask;
   logic [7:0] r_code;
   logic [7:0] r_byte;
   logic       r_byte_valid;
   logic       r_key_ready;
   logic       r_unmapped;

   logic       w_mapped;
   logic [7:0] w_mask;
   logic [7:0] w_code;
   logic [7:0] w_cur_mask;
   logic [7:0] w_cur_code;
   logic [7:0] w_next_byte;
   logic       w_byte_xfer;
   logic       w_last;
   logic       w_in_pkt;
   logic       w_in_gap;
   logic       w_pkt_done;
   logic       w_to_release;

   function automatic logic [7:0] pkt_byte(input logic [2:0] idx, input logic [7:0] mask,
                                           input logic [7:0] code);
      case (idx)
         3'd0:    pkt_byte = MAGIC[23:16];
         3'd1:    pkt_byte = MAGIC[15:8];
         3'd2:    pkt_byte = MAGIC[7:0];
         3'd3:    pkt_byte = mask;
         3'd4:    pkt_byte = 8'h00;
         default: pkt_byte = code;
      endcase
   endfunction

   always_comb begin
      // NOTE: every signal gets a default before any branch, so no path can infer a latch.
      w_mapped = 1'b1;
      w_mask   = 8'h00;
      w_code   = 8'h00;
      if (i_key >= 8'h61 && i_key <= 8'h7A) begin
         w_code = i_key - 8'h5D;
      end else if (i_key >= 8'h41 && i_key <= 8'h5A) begin
         w_mask = 8'h02;
         w_code = i_key - 8'h3D;
      end else if (i_key >= 8'h31 && i_key <= 8'h39) begin
         w_code = i_key - 8'h13;
      end else begin
         case (i_key)
            8'h30:   w_code = 8'h27;
            8'h0D:   w_code = 8'h28;
            8'h1B:   w_code = 8'h29;
            8'h08:   w_code = 8'h2A;
            8'h09:   w_code = 8'h2B;
            8'h20:   w_code = 8'h2C;
            default: w_mapped = 1'b0;
         endcase
      end
   end

   // Release packets reuse the press datapath with mask and code forced to zero.
   assign w_cur_mask   = (r_state == ST_RELEASE) ? 8'h00 : r_mask;
   assign w_cur_code   = (r_state == ST_RELEASE) ? 8'h00 : r_code;
   assign w_next_byte  = pkt_byte(3'(r_idx + 3'd1), w_cur_mask, w_cur_code);
   assign w_byte_xfer  = r_byte_valid & i_byte_ready;
   assign w_last       = (r_idx == 3'd5);
   assign w_in_pkt     = (r_state == ST_PRESS) || (r_state == ST_RELEASE);
   assign w_in_gap     = (r_state == ST_GAP_P) || (r_state == ST_GAP_R);
   assign w_to_release = SEND_RELEASE && ((r_state == ST_PRESS) || (r_state == ST_GAP_P));
   assign w_pkt_done   = (w_in_pkt && w_byte_xfer && w_last && (GAP_CYC == 8'd0)) ||
                         (w_in_gap && (r_gap_cnt <= 8'd1));

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= ST_IDLE;
         r_idx        <= 3'd0;
         r_gap_cnt    <= 8'd0;
         r_mask       <= 8'h00;
         r_code       <= 8'h00;
         r_byte       <= 8'h00;
         r_byte_valid <= 1'b0;
         r_key_ready  <= 1'b1;
         r_unmapped   <= 1'b0;
      end else begin
         r_unmapped <= 1'b0;
         if (w_pkt_done) begin
            r_idx <= 3'd0;
            if (w_to_release) begin
               r_state      <= ST_RELEASE;
               r_byte       <= MAGIC[23:16];
               r_byte_valid <= 1'b1;
            end else begin
               r_state      <= ST_IDLE;
               r_byte_valid <= 1'b0;
               r_key_ready  <= 1'b1;
            end
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (i_key_valid) begin
                     if (w_mapped) begin
                        r_state      <= ST_PRESS;
                        r_mask       <= w_mask;
                        r_code       <= w_code;
                        r_idx        <= 3'd0;
                        r_byte       <= MAGIC[23:16];
                        r_byte_valid <= 1'b1;
                        r_key_ready  <= 1'b0;
                     end else begin
                        r_unmapped <= 1'b1;
                     end
                  end
               end
               ST_PRESS, ST_RELEASE: begin
                  if (w_byte_xfer) begin
                     if (!w_last) begin
                        r_idx  <= 3'(r_idx + 3'd1);
                        r_byte <= w_next_byte;
                     end else begin
                        r_byte_valid <= 1'b0;
                        r_gap_cnt    <= GAP_CYC;
                        r_state      <= (r_state == ST_PRESS) ? ST_GAP_P : ST_GAP_R;
                     end
                  end
               end
               ST_GAP_P, ST_GAP_R: begin
                  r_gap_cnt <= r_gap_cnt - 8'd1;
               end
               default: begin
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign o_key_ready  = r_key_ready;
   assign o_byte       = r_byte;
   assign o_byte_valid = r_byte_valid;
   assign o_unmapped   = r_unmapped;

endmodule

// File: tb/tb_usbkeys_tx.sv
// Directed bench for usbkeys_tx: packet contents and timing, stalls, unmapped keys,
// gap/no-release variant and reset mid-packet followed by a parsed loopback message.
module tb_usbkeys_tx;

   typedef struct packed {
      logic [7:0] key;
      logic [7:0] mask;
      logic [7:0] code;
   } vec_t;

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b1;
   logic [7:0] i_key0 = 8'h00;
   logic       i_key_valid0 = 1'b0;
   logic       o_key_ready0;
   logic [7:0] o_byte0;
   logic       o_byte_valid0;
   logic       i_byte_ready0 = 1'b1;
   logic       o_unmapped0;
   logic [7:0] i_key1 = 8'h00;
   logic       i_key_valid1 = 1'b0;
   logic       o_key_ready1;
   logic [7:0] o_byte1;
   logic       o_byte_valid1;
   logic       i_byte_ready1 = 1'b1;
   logic       o_unmapped1;

   int         n_total = 0;
   int         n_bad = 0;
   int         cyc = 0;
   bit         mon_on = 1'b0;
   bit         rand_mode = 1'b0;
   bit         ready_force = 1'b1;
   bit         stall_prev = 1'b0;
   logic [7:0] stall_byte = 8'h00;
   logic [7:0] cap_q[$];
   int         cap_t[$];
   logic [7:0] exp_q[$];

   vec_t vecs[12] = '{24'h610004, 24'h410204, 24'h300027, 24'h0D0028,
                      24'h7A001D, 24'h5A021D, 24'h31001E, 24'h390026,
                      24'h20002C, 24'h1B0029, 24'h08002A, 24'h09002B};
   logic [7:0] bad_keys[5] = '{8'h7E, 8'h40, 8'h7B, 8'h2F, 8'h3A};
   logic [7:0] msg[5]      = '{8'h48, 8'h69, 8'h20, 8'h31, 8'h0D};

   usbkeys_tx dut0 (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_key       (i_key0),
      .i_key_valid (i_key_valid0),
      .o_key_ready (o_key_ready0),
      .o_byte      (o_byte0),
      .o_byte_valid(o_byte_valid0),
      .i_byte_ready(i_byte_ready0),
      .o_unmapped  (o_unmapped0)
   );

   usbkeys_tx #(.MAGIC(24'h57AB01), .SEND_RELEASE(1'b0), .GAP(4)) dut1 (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_key       (i_key1),
      .i_key_valid (i_key_valid1),
      .o_key_ready (o_key_ready1),
      .o_byte      (o_byte1),
      .o_byte_valid(o_byte_valid1),
      .i_byte_ready(i_byte_ready1),
      .o_unmapped  (o_unmapped1)
   );

   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) cyc++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Byte capture plus hold-while-stalled and ready/valid exclusivity on dut0.
   always @(negedge i_clk) begin
      if (mon_on) begin
         if (o_byte_valid0 && i_byte_ready0) begin
            cap_q.push_back(o_byte0);
            cap_t.push_back(cyc);
         end
         if (stall_prev) begin
            check("stall_valid", {31'd0, o_byte_valid0}, 32'd1);
            check("stall_byte", {24'd0, o_byte0}, {24'd0, stall_byte});
         end
         check("ready_vs_valid", {31'd0, o_key_ready0 & o_byte_valid0}, 32'd0);
         stall_prev = o_byte_valid0 && !i_byte_ready0 && !i_rst;
         stall_byte = o_byte0;
      end
   end

   initial begin
      forever begin
         @(posedge i_clk);
         #2;
         i_byte_ready0 = rand_mode ? 1'($urandom_range(0, 1)) : ready_force;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic at_stamp(input int s);
      do @(negedge i_clk); while (cyc < s);
      #1;
   endtask

   task automatic send_key0(input logic [7:0] k, output int s);
      int n = 0;
      @(posedge i_clk);
      #1;
      i_key0       = k;
      i_key_valid0 = 1'b1;
      @(negedge i_clk);
      while (!o_key_ready0 && n < 400) begin
         @(negedge i_clk);
         n++;
      end
      check($sformatf("accept_%0h", k), {31'd0, o_key_ready0}, 32'd1);
      s = cyc;
      @(posedge i_clk);
      #1;
      i_key_valid0 = 1'b0;
   endtask

   task automatic push_pkt(input logic [7:0] m, input logic [7:0] c);
      exp_q.push_back(8'h57);
      exp_q.push_back(8'hAB);
      exp_q.push_back(8'h01);
      exp_q.push_back(m);
      exp_q.push_back(8'h00);
      exp_q.push_back(c);
   endtask

   function automatic logic [7:0] decode(input logic [7:0] m, input logic [7:0] c);
      if (c >= 8'h04 && c <= 8'h1D) return (m == 8'h02) ? 8'h41 + (c - 8'h04) : 8'h61 + (c - 8'h04);
      if (c >= 8'h1E && c <= 8'h26) return 8'h31 + (c - 8'h1E);
      case (c)
         8'h27:   return 8'h30;
         8'h28:   return 8'h0D;
         8'h29:   return 8'h1B;
         8'h2A:   return 8'h08;
         8'h2B:   return 8'h09;
         8'h2C:   return 8'h20;
         default: return 8'hFF;
      endcase
   endfunction

   task automatic run_directed(input vec_t v);
      int s;
      cap_q.delete();
      cap_t.delete();
      exp_q.delete();
      push_pkt(v.mask, v.code);
      push_pkt(8'h00, 8'h00);
      send_key0(v.key, s);
      at_stamp(s + 12);
      check($sformatf("busy_%0h", v.key), {31'd0, o_key_ready0}, 32'd0);
      at_stamp(s + 13);
      check($sformatf("ready_back_%0h", v.key), {31'd0, o_key_ready0}, 32'd1);
      check($sformatf("count_%0h", v.key), cap_q.size(), 32'd12);
      for (int j = 0; j < cap_q.size() && j < 12; j++) begin
         check($sformatf("byte_%0h_%0d", v.key, j), {24'd0, cap_q[j]}, {24'd0, exp_q[j]});
         check($sformatf("time_%0h_%0d", v.key, j), cap_t[j], s + 1 + j);
      end
   endtask

   initial begin
      int s;
      int n;
      int pos;
      vec_t v;
      logic [7:0] got[$];

      // Reset values on both instances
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      check("rst_ready0", {31'd0, o_key_ready0}, 32'd1);
      check("rst_valid0", {31'd0, o_byte_valid0}, 32'd0);
      check("rst_byte0", {24'd0, o_byte0}, 32'd0);
      check("rst_unmapped0", {31'd0, o_unmapped0}, 32'd0);
      check("rst_ready1", {31'd0, o_key_ready1}, 32'd1);
      check("rst_valid1", {31'd0, o_byte_valid1}, 32'd0);
      @(posedge i_clk);
      #1;
      i_rst  = 1'b0;
      mon_on = 1'b1;

      // Every mapped class with ready held high: exact bytes and cycle-exact timing
      foreach (vecs[i]) run_directed(vecs[i]);

      // Unmapped keys, including the neighbours of each mapped range
      foreach (bad_keys[i]) begin
         n = cap_q.size();
         send_key0(bad_keys[i], s);
         at_stamp(s + 1);
         check($sformatf("unm_pulse_%0h", bad_keys[i]), {31'd0, o_unmapped0}, 32'd1);
         check($sformatf("unm_valid_%0h", bad_keys[i]), {31'd0, o_byte_valid0}, 32'd0);
         check($sformatf("unm_ready_%0h", bad_keys[i]), {31'd0, o_key_ready0}, 32'd1);
         at_stamp(s + 2);
         check($sformatf("unm_clear_%0h", bad_keys[i]), {31'd0, o_unmapped0}, 32'd0);
         check($sformatf("unm_nobytes_%0h", bad_keys[i]), cap_q.size(), n);
      end

      // GAP=4, no release: two keys offered back to back
      @(posedge i_clk);
      #1;
      i_key1       = 8'h61;
      i_key_valid1 = 1'b1;
      @(negedge i_clk);
      check("gap_first_ready", {31'd0, o_key_ready1}, 32'd1);
      s = cyc;
      @(posedge i_clk);
      #1;
      i_key1 = 8'h62;
      for (int t = 1; t <= 23; t++) begin
         bit ev;
         bit er;
         logic [7:0] eb;
         at_stamp(s + t);
         ev = (t >= 1 && t <= 6) || (t >= 12 && t <= 17);
         er = (t == 11) || (t >= 22);
         eb = (t == 6) ? 8'h04 : (t == 17) ? 8'h05 :
              (t == 1 || t == 12) ? 8'h57 : (t == 2 || t == 13) ? 8'hAB :
              (t == 3 || t == 14) ? 8'h01 : 8'h00;
         check($sformatf("gap_valid_t%0d", t), {31'd0, o_byte_valid1}, {31'd0, ev});
         check($sformatf("gap_ready_t%0d", t), {31'd0, o_key_ready1}, {31'd0, er});
         if (ev) check($sformatf("gap_byte_t%0d", t), {24'd0, o_byte1}, {24'd0, eb});
         if (t == 11) begin
            @(posedge i_clk);
            #1;
            i_key_valid1 = 1'b0;
         end
      end

      // Random downstream stalls over 200 keys
      cap_q.delete();
      cap_t.delete();
      exp_q.delete();
      rand_mode = 1'b1;
      for (int k = 0; k < 200; k++) begin
         v = vecs[$urandom_range(0, 11)];
         push_pkt(v.mask, v.code);
         push_pkt(8'h00, 8'h00);
         send_key0(v.key, s);
         repeat ($urandom_range(0, 2)) @(posedge i_clk);
      end
      n = 0;
      while (cap_q.size() < exp_q.size() && n < 2000) begin
         @(negedge i_clk);
         n++;
      end
      #1;
      rand_mode = 1'b0;
      check("rand_count", cap_q.size(), exp_q.size());
      for (int j = 0; j < cap_q.size() && j < exp_q.size(); j++)
         check($sformatf("rand_byte_%0d", j), {24'd0, cap_q[j]}, {24'd0, exp_q[j]});

      // Reset three bytes into 'z', with a key offered during reset, then loopback message
      repeat (4) @(posedge i_clk);
      cap_q.delete();
      cap_t.delete();
      send_key0(8'h7A, s);
      at_stamp(s + 3);
      @(posedge i_clk);
      #1;
      i_rst        = 1'b1;
      ready_force  = 1'b0;
      i_key0       = 8'h71;
      i_key_valid0 = 1'b1;
      at_stamp(s + 5);
      check("midrst_valid", {31'd0, o_byte_valid0}, 32'd0);
      check("midrst_ready", {31'd0, o_key_ready0}, 32'd1);
      check("midrst_byte", {24'd0, o_byte0}, 32'd0);
      check("midrst_unmapped", {31'd0, o_unmapped0}, 32'd0);
      @(posedge i_clk);
      #1;
      i_rst        = 1'b0;
      i_key_valid0 = 1'b0;
      ready_force  = 1'b1;
      at_stamp(s + 6);
      check("rstkey_ignored", {31'd0, o_byte_valid0}, 32'd0);
      check("trunc_count", cap_q.size(), 32'd3);
      foreach (msg[i]) send_key0(msg[i], s);
      n = 0;
      while (cap_q.size() < 63 && n < 200) begin
         @(negedge i_clk);
         n++;
      end
      #1;
      check("loop_bytes", cap_q.size(), 32'd63);
      pos = 0;
      while (pos + 5 < cap_q.size()) begin
         if ({cap_q[pos], cap_q[pos + 1], cap_q[pos + 2]} == 24'h57AB01 && cap_q[pos + 4] == 8'h00) begin
            if (cap_q[pos + 5] != 8'h00) got.push_back(decode(cap_q[pos + 3], cap_q[pos + 5]));
            pos += 6;
         end else begin
            pos++;
         end
      end
      check("loop_keys", got.size(), 32'd5);
      for (int j = 0; j < got.size() && j < 5; j++)
         check($sformatf("loop_key_%0d", j), {24'd0, got[j]}, {24'd0, msg[j]});

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
